modexp_stream_ctrl: RTL and testbench



---
 rtl/modexp_stream_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_modexp_stream_ctrl.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_stream_ctrl.sv
// modexp_stream_ctrl: host-side sequencer streaming operands into a
// word-serial ModExp core, waiting for completion and gathering the result.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin one exponentiation (taken only when idle)
//   message..t           OPW-bit operands, little-endian words
//   nprime0_in           -n^-1 mod 2^64, captured when start is taken
//   busy, done, error    run status; done/error are one-cycle pulses
//   result               gathered result, held until the next start
//   m_buf..t_buf         word-serial operand buses towards ModExp
//   nprime0              captured nprime0_in
//   startInput, startCompute, getResult   ModExp strobes
//   exp_state, res_out   ModExp status and word-serial result
module modexp_stream_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 64,
  parameter int TIMEOUT    = 2**24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  message,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  exponent,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  modulus,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  r,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  t,
  input  logic [63:0]                      nprime0_in,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  result,
  output logic [DATA_WIDTH-1:0]            m_buf,
  output logic [DATA_WIDTH-1:0]            e_buf,
  output logic [DATA_WIDTH-1:0]            n_buf,
  output logic [DATA_WIDTH-1:0]            r_buf,
  output logic [DATA_WIDTH-1:0]            t_buf,
  output logic [63:0]                      nprime0,
  output logic                             startInput,
  output logic                             startCompute,
  output logic                             getResult,
  input  logic [4:0]                       exp_state,
  input  logic [DATA_WIDTH-1:0]            res_out
);

  localparam int KW = $clog2(NUM_WORDS + 1);
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);
  localparam logic [KW-1:0] K_END  = KW'(NUM_WORDS);
  localparam logic [31:0]   W_LAST = 32'(TIMEOUT - 1);
  localparam logic [4:0]    COMPLETE = 5'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_READ,
    S_FIN
  } state_t;

  state_t        state, state_d;
  logic [KW-1:0] k, k_d;
  logic [31:0]   w, w_d;
  logic          err_d;

  logic [DATA_WIDTH-1:0] m_w [NUM_WORDS];
  logic [DATA_WIDTH-1:0] e_w [NUM_WORDS];
  logic [DATA_WIDTH-1:0] n_w [NUM_WORDS];
  logic [DATA_WIDTH-1:0] r_w [NUM_WORDS];
  logic [DATA_WIDTH-1:0] t_w [NUM_WORDS];
  logic [AW-1:0]         ka;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    assign m_w[g] = message[g*DATA_WIDTH +: DATA_WIDTH];
    assign e_w[g] = exponent[g*DATA_WIDTH +: DATA_WIDTH];
    assign n_w[g] = modulus[g*DATA_WIDTH +: DATA_WIDTH];
    assign r_w[g] = r[g*DATA_WIDTH +: DATA_WIDTH];
    assign t_w[g] = t[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ka = AW'(k);

  always_comb begin
    state_d      = state;
    k_d          = k;
    w_d          = w;
    err_d        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    startInput   = 1'b0;
    startCompute = 1'b0;
    getResult    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        startInput = 1'b1;
        if (k == K_LAST) begin
          state_d = S_WAIT;
          k_d     = '0;
          w_d     = '0;
        end else begin
          k_d = k + KW'(1);
        end
      end
      S_WAIT: begin
        busy         = 1'b1;
        startCompute = 1'b1;
        w_d          = w + 32'd1;
        if (exp_state == COMPLETE) begin
          state_d = S_READ;
          k_d     = '0;
        end else if (w == W_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        getResult = 1'b1;
        // word 0 of the read window is ModExp pipeline fill
        if (k == K_END) begin
          state_d = S_FIN;
          k_d     = '0;
        end else begin
          k_d = k + KW'(1);
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_buf = '0;
    e_buf = '0;
    n_buf = '0;
    r_buf = '0;
    t_buf = '0;
    if (state == S_LOAD) begin
      m_buf = m_w[ka];
      e_buf = e_w[ka];
      n_buf = n_w[ka];
      r_buf = r_w[ka];
      t_buf = t_w[ka];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= '0;
      w       <= '0;
      error   <= 1'b0;
      nprime0 <= '0;
      result  <= '0;
    end else begin
      state <= state_d;
      k     <= k_d;
      w     <= w_d;
      error <= err_d;
      if (state == S_IDLE && start) begin
        nprime0 <= nprime0_in;
        result  <= '0;
      end
      if (state == S_READ) begin
        for (int j = 0; j < NUM_WORDS; j++) begin
          if (k == KW'(j + 1)) begin
            result[j*DATA_WIDTH +: DATA_WIDTH] <= res_out;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// tb_modexp_stream_ctrl: randomized bench with a timestamp-based run model
// and a ModExp stub; checks every output on every cycle.
module tb_modexp_stream_ctrl;

  localparam int DW  = 64;
  localparam int N   = 64;
  localparam int TO  = 100;
  localparam int OPW = DW * N;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [OPW-1:0] message = '0;
  logic [OPW-1:0] exponent = '0;
  logic [OPW-1:0] modulus = '0;
  logic [OPW-1:0] r_op = '0;
  logic [OPW-1:0] t_op = '0;
  logic [63:0]    nprime0_in = '0;
  logic           busy, done, error;
  logic [OPW-1:0] result;
  logic [DW-1:0]  m_buf, e_buf, n_buf, r_buf, t_buf;
  logic [63:0]    nprime0;
  logic           startInput, startCompute, getResult;
  logic [4:0]     exp_state = '0;
  logic [DW-1:0]  res_out = '0;

  always #5 clk = ~clk;

  modexp_stream_ctrl #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (N),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .message     (message),
    .exponent    (exponent),
    .modulus     (modulus),
    .r           (r_op),
    .t           (t_op),
    .nprime0_in  (nprime0_in),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .result      (result),
    .m_buf       (m_buf),
    .e_buf       (e_buf),
    .n_buf       (n_buf),
    .r_buf       (r_buf),
    .t_buf       (t_buf),
    .nprime0     (nprime0),
    .startInput  (startInput),
    .startCompute(startCompute),
    .getResult   (getResult),
    .exp_state   (exp_state),
    .res_out     (res_out)
  );

  int total = 0;
  int bad = 0;

  // run model: timestamps of the current run
  int cyc = 0;
  int acc = -1;
  int rd = -1;
  int errc = -1;
  bit armed = 0;
  logic [OPW-1:0] mres = '0;
  logic [63:0] mnp = '0;
  int n_fin = 0;

  // observed events
  int n_done = 0;
  int n_err = 0;
  int last_acc = 0;
  int last_done = 0;
  int last_err = 0;

  // stimulus knobs
  int w_target = 5;
  int rd_mode = 0;
  bit noise = 0;
  bit rnd_ops = 0;
  bit rst_rand = 0;
  bit hold_rnd = 0;
  bit start_req = 0;
  int rst_cnt = 3;

  // ModExp stub
  logic [63:0] cap_m, cap_e, cap_n, mx_val;

  function automatic logic [63:0] wd(input logic [OPW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] b0,
                                         input logic [63:0] e0,
                                         input logic [63:0] m);
    logic [63:0] res, b, e;
    if (m == 0) return 0;
    res = 1 % m;
    b = b0 % m;
    e = e0;
    while (e != 0) begin
      if (e[0]) res = (res * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return res;
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    logic [OPW-1:0] v;
    for (int i = 0; i < OPW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [4:0] nonnine();
    int v;
    v = $urandom_range(0, 30);
    if (v >= 9) v++;
    return 5'(v);
  endfunction

  function automatic bit in_load();
    return acc >= 0 && cyc >= acc + 1 && cyc <= acc + N;
  endfunction
  function automatic bit in_wait();
    return acc >= 0 && cyc >= acc + N + 1 && rd < 0;
  endfunction
  function automatic bit in_read();
    return acc >= 0 && rd >= 0 && cyc >= rd && cyc <= rd + N;
  endfunction
  function automatic bit in_fin();
    return acc >= 0 && rd >= 0 && cyc == rd + N + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  task automatic chk_res(input string nm, input logic [OPW-1:0] e);
    int j;
    total++;
    if (result !== e) begin
      bad++;
      j = 0;
      while (j < N - 1 && wd(result, j) === wd(e, j)) j++;
      $display("FAIL %s cyc=%0d word %0d got=%h want=%h",
               nm, cyc, j, wd(result, j), wd(e, j));
    end
  endtask

  task automatic check_outputs();
    bit ld;
    int k;
    if (!armed) return;
    ld = in_load();
    k = cyc - acc - 1;
    chk("busy", busy, acc >= 0);
    chk("done", done, in_fin());
    chk("error", error, cyc == errc);
    chk("done_err_excl", done & error, 0);
    chk("startInput", startInput, ld);
    chk("startCompute", startCompute, in_wait());
    chk("getResult", getResult, in_read());
    chk("m_buf", m_buf, ld ? wd(message, k) : 64'd0);
    chk("e_buf", e_buf, ld ? wd(exponent, k) : 64'd0);
    chk("n_buf", n_buf, ld ? wd(modulus, k) : 64'd0);
    chk("r_buf", r_buf, ld ? wd(r_op, k) : 64'd0);
    chk("t_buf", t_buf, ld ? wd(t_op, k) : 64'd0);
    chk("nprime0", nprime0, mnp);
    chk_res("result", mres);
    if (done === 1'b1) begin
      n_done++;
      last_done = cyc;
    end
    if (error === 1'b1) begin
      n_err++;
      last_err = cyc;
    end
  endtask

  task automatic drive_inputs();
    int i, c;
    if (rst_rand && $urandom_range(0, 799) == 0) rst_cnt = 1;
    reset = rst_cnt > 0;
    if (rst_cnt > 0) rst_cnt--;
    if (hold_rnd && acc >= 0 && !start_req && $urandom_range(0, 99) == 0)
      start_req = 1;
    if (acc < 0) begin
      start = start_req || (noise && $urandom_range(0, 15) == 0);
      if (rnd_ops) begin
        message = rnd_op();
        exponent = rnd_op();
        modulus = rnd_op();
        r_op = rnd_op();
        t_op = rnd_op();
      end
    end else begin
      start = start_req || (noise && $urandom_range(0, 2) == 0);
    end
    nprime0_in = {$urandom, $urandom};
    if (in_load() && cyc == acc + 1) begin
      cap_m = m_buf;
      cap_e = e_buf;
      cap_n = n_buf;
    end
    if (in_wait()) begin
      i = cyc - (acc + N + 1);
      exp_state = (w_target > 0 && i == w_target - 1) ? 5'd9 : nonnine();
    end else begin
      exp_state = (noise && $urandom_range(0, 3) == 0) ? 5'd9 : nonnine();
    end
    res_out = {$urandom, $urandom};
    if (in_read()) begin
      c = cyc - rd;
      if (c == 0) mx_val = powmod(cap_m, cap_e, cap_n);
      if (rd_mode == 1) res_out = DW'(c);
      if (rd_mode == 2 && c >= 1) res_out = (c == 1) ? mx_val : '0;
    end
  endtask

  task automatic update_model();
    int i, c;
    if (reset) begin
      acc = -1;
      rd = -1;
      errc = -1;
      mres = '0;
      mnp = '0;
      armed = 1;
    end else if (acc < 0) begin
      if (start) begin
        acc = cyc;
        rd = -1;
        mres = '0;
        mnp = nprime0_in;
        last_acc = cyc;
        start_req = 0;
      end
    end else if (in_wait()) begin
      i = cyc - (acc + N + 1);
      if (exp_state == 5'd9) begin
        rd = cyc + 1;
      end else if (i == TO - 1) begin
        errc = cyc + 1;
        acc = -1;
      end
    end else if (in_read()) begin
      c = cyc - rd;
      if (c >= 1) mres[(c-1)*DW +: DW] = res_out;
    end else if (in_fin()) begin
      acc = -1;
      rd = -1;
      n_fin++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    update_model();
    @(posedge clk);
    cyc++;
  endtask

  task automatic bound_fail(input string nm, input int n, input int lim);
    total++;
    if (n >= lim) begin
      bad++;
      $display("FAIL %s cyc=%0d waited=%0d limit=%0d", nm, cyc, n, lim);
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    while (acc < 0 && n < 200) begin
      step();
      n++;
    end
    bound_fail("accept_timeout", n, 200);
  endtask

  task automatic run_to_idle();
    int n = 0;
    while ((start_req || acc >= 0) && n < 2000) begin
      step();
      n++;
    end
    bound_fail("idle_timeout", n, 2000);
  endtask

  task automatic set_small_ops();
    message = '0;
    exponent = '0;
    modulus = '0;
    r_op = '0;
    t_op = '0;
    message[63:0] = 64'd8;
    exponent[63:0] = 64'd13;
    modulus[63:0] = 64'd77;
    r_op[63:0] = 64'd1;
    t_op[63:0] = 64'd1;
  endtask

  task automatic run_modexp_50();
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    set_small_ops();
    rd_mode = 2;
    w_target = 7;
    start_req = 1;
    wait_accept();
    run_to_idle();
    #1;
    chk("mx_word0", result[63:0], 64'd50);
    chk("mx_upper_zero", {63'd0, result[OPW-1:64] == '0}, 64'd1);
    chk("mx_done_once", n_done - d0, 1);
    chk("mx_no_err", n_err - e0, 0);
  endtask

  initial begin
    int n, d0, e0, a0;

    // reset state
    rst_cnt = 3;
    repeat (4) step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_nprime0", nprime0, 0);
    chk("rst_result_zero", {63'd0, result == '0}, 64'd1);

    // reset wins over start in the same cycle
    rst_cnt = 1;
    start_req = 1;
    step();
    #1;
    chk("rst_over_start", busy, 0);
    step();
    #1;
    chk("start_after_rst", busy, 1);
    run_to_idle();

    // load trace: word i = i+1
    for (int i = 0; i < N; i++) begin
      message[i*DW +: DW] = DW'(i + 1);
      exponent[i*DW +: DW] = DW'(i + 1);
      modulus[i*DW +: DW] = DW'(i + 1);
      r_op[i*DW +: DW] = DW'(i + 1);
      t_op[i*DW +: DW] = DW'(i + 1);
    end
    rd_mode = 0;
    w_target = 4;
    start_req = 1;
    wait_accept();
    for (int i = 0; i < N; i++) begin
      #1;
      chk("trace_m", m_buf, 64'(i + 1));
      chk("trace_si", startInput, 1);
      step();
    end
    #1;
    chk("trace_si_off", startInput, 0);
    chk("trace_m_zero", m_buf, 0);
    run_to_idle();

    // 8^13 mod 77
    run_modexp_50();

    // res_out = c on read cycle c, W = 3
    rd_mode = 1;
    w_target = 3;
    start_req = 1;
    wait_accept();
    run_to_idle();
    #1;
    chk("latency", last_done - last_acc + 1, 64'd134);
    for (int j = 0; j < N; j++) chk("ramp_word", wd(result, j), 64'(j + 1));

    // timeout
    d0 = n_done;
    e0 = n_err;
    w_target = 0;
    rd_mode = 0;
    start_req = 1;
    wait_accept();
    a0 = last_acc;
    run_to_idle();
    step();
    #1;
    chk("to_err_once", n_err - e0, 1);
    chk("to_no_done", n_done - d0, 0);
    chk("to_distance", last_err - (a0 + N + 1), 64'd100);
    chk("to_result_zero", {63'd0, result == '0}, 64'd1);

    // reset on 10th wait cycle, then a clean run
    d0 = n_done;
    e0 = n_err;
    w_target = 30;
    start_req = 1;
    wait_accept();
    n = 0;
    while (!(in_wait() && cyc - (acc + N + 1) == 9) && n < 400) begin
      step();
      n++;
    end
    bound_fail("wait10_timeout", n, 400);
    rst_cnt = 1;
    step();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sc", startCompute, 0);
    chk("mid_rst_res", {63'd0, result == '0}, 64'd1);
    chk("mid_rst_np", nprime0, 0);
    chk("mid_rst_evt", (n_done - d0) + (n_err - e0), 0);
    run_modexp_50();

    // noise: stray starts and exp_state=9 outside WAIT
    d0 = n_done;
    n = n_fin;
    noise = 1;
    rd_mode = 0;
    w_target = 10;
    repeat (700) step();
    noise = 0;
    run_to_idle();
    step();
    chk("noise_done_per_run", n_done - d0, n_fin - n);

    // randomized runs
    rnd_ops = 1;
    hold_rnd = 1;
    rst_rand = 1;
    for (int run = 0; run < 14; run++) begin
      w_target = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30);
      rd_mode = $urandom_range(0, 1);
      start_req = 1;
      run_to_idle();
    end
    rst_rand = 0;
    hold_rnd = 0;
    run_to_idle();
    repeat (3) step();
    chk("done_count", n_done, n_fin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
